skid_buffer_sync_rst_n: RTL and testbench

SKID_BUFFER_SYNC_RST_N -- requirements
Module: skid_buffer_sync_rst_n

---
 rtl/skid_buffer_sync_rst_n.sv | 99 +++++++++
 tb/tb_skid_buffer_sync_rst_n.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/skid_buffer_sync_rst_n.sv
// Two-entry valid/ready pipeline stage (main + skid register) with registered
// handshake outputs, so no combinational path runs from in_valid/out_ready to any output.
module skid_buffer_sync_rst_n #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] main_reg, main_next;
  logic [WIDTH-1:0] skid_reg, skid_next;

  logic accept;
  logic handoff;
  logic main_load;
  logic main_from_skid;
  logic skid_load;

  assign in_ready  = (state_reg != FULL);
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign count     = (state_reg == FULL) ? 2'd2 :
                     (state_reg == BUSY) ? 2'd1 : 2'd0;

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

  // Next state plus register load strobes; the data path below only acts on the strobes.
  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          main_load  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (accept && handoff) begin
          main_load = 1'b1;
        end else if (accept) begin
          skid_load  = 1'b1;
          state_next = FULL;
        end else if (handoff) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (handoff) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          state_next     = BUSY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  // Per-bit load muxes: main takes in_data or the skid copy; both hold otherwise.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign main_next[gi] = !main_load     ? main_reg[gi] :
                             main_from_skid ? skid_reg[gi] : in_data[gi];
      assign skid_next[gi] = skid_load ? in_data[gi] : skid_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
    end
  end

endmodule

// File: tb/tb_skid_buffer_sync_rst_n.sv
// Directed checks on a 4-bit instance, then random traffic with a FIFO scoreboard on an 8-bit one.
module tb_skid_buffer_sync_rst_n;

  logic       clk;
  logic       sync_rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] count;

  logic       r_rst_n;
  logic       r_in_valid;
  logic       r_in_ready;
  logic [7:0] r_in_data;
  logic       r_out_valid;
  logic       r_out_ready;
  logic [7:0] r_out_data;
  logic [1:0] r_count;

  int checks;
  int passes;

  skid_buffer_sync_rst_n #(.WIDTH(4)) u_dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count)
  );

  skid_buffer_sync_rst_n #(.WIDTH(8)) u_dut8 (
    .clk        (clk),
    .sync_rst_n (r_rst_n),
    .in_valid   (r_in_valid),
    .in_ready   (r_in_ready),
    .in_data    (r_in_data),
    .out_valid  (r_out_valid),
    .out_ready  (r_out_ready),
    .out_data   (r_out_data),
    .count      (r_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      passes++;
    end
  endtask

  // Advance past one rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t rst_n=%b in_v=%b in_d=%h out_r=%b | out_v=%b out_d=%h in_r=%b count=%0d",
             $time, sync_rst_n, in_valid, in_data, out_ready, out_valid, out_data, in_ready, count);
  endtask

  task automatic expect_state(input string tag, input logic ov, input logic [3:0] od,
                              input logic ir, input logic [1:0] cnt);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({tag, ".out_data"},  32'(out_data),  32'(od));
    check({tag, ".in_ready"},  32'(in_ready),  32'(ir));
    check({tag, ".count"},     32'(count),     32'(cnt));
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] exp_word;

  initial begin
    checks      = 0;
    passes      = 0;
    sync_rst_n  = 1'b0;
    in_valid    = 1'b1;
    in_data     = 4'hF;
    out_ready   = 1'b0;
    r_rst_n     = 1'b0;
    r_in_valid  = 1'b0;
    r_in_data   = 8'h00;
    r_out_ready = 1'b0;

    // Reset held 2 cycles with a valid input present
    tick();
    tick();
    expect_state("reset", 1'b0, 4'h0, 1'b1, 2'd0);

    // Streaming at full throughput
    sync_rst_n = 1'b1;
    out_ready  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(i);
      tick();
      expect_state($sformatf("stream%0d", i), 1'b1, 4'(i), 1'b1, 2'd1);
    end
    in_valid = 1'b0;
    tick();
    expect_state("stream_drain", 1'b0, 4'h4, 1'b1, 2'd0);

    // Backpressure: 5 then 6 with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h5;
    tick();
    expect_state("bp_5", 1'b1, 4'h5, 1'b1, 2'd1);
    in_data = 4'h6;
    tick();
    expect_state("bp_full", 1'b1, 4'h5, 1'b0, 2'd2);
    in_valid = 1'b0;
    tick();
    expect_state("bp_hold", 1'b1, 4'h5, 1'b0, 2'd2);
    out_ready = 1'b1;
    tick();
    expect_state("bp_deliver6", 1'b1, 4'h6, 1'b1, 2'd1);
    tick();
    expect_state("bp_empty", 1'b0, 4'h6, 1'b1, 2'd0);

    // Stalled input while FULL: 9 must never be taken
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hA;
    tick();
    in_data = 4'hB;
    tick();
    in_data = 4'h9;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("stall%0d", i), 1'b1, 4'hA, 1'b0, 2'd2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_state("stall_deliverB", 1'b1, 4'hB, 1'b1, 2'd1);
    tick();
    expect_state("stall_empty", 1'b0, 4'hB, 1'b1, 2'd0);

    // Reset mid-operation from FULL holding 7, 8; handshake in reset cycle is void
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'h7;
    tick();
    in_data = 4'h8;
    tick();
    expect_state("pre_rst_full", 1'b1, 4'h7, 1'b0, 2'd2);
    // Dropping reset between edges must not disturb the outputs
    sync_rst_n = 1'b0;
    #2;
    expect_state("rst_no_edge", 1'b1, 4'h7, 1'b0, 2'd2);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    expect_state("mid_rst", 1'b0, 4'h0, 1'b1, 2'd0);
    sync_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_state($sformatf("post_rst%0d", i), 1'b0, 4'h0, 1'b1, 2'd0);
    end

    // Random traffic on the 8-bit instance
    @(posedge clk);
    #1;
    r_rst_n = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      r_in_valid  = ($urandom_range(0, 99) < 60);
      r_in_data   = 8'($urandom_range(0, 255));
      r_out_ready = ($urandom_range(0, 99) < 55);
      check("rand_count_bound", 32'(r_count <= 2'd2), 32'd1);
      check("rand_count", 32'(r_count), 32'(exp_q.size()));
      check("rand_in_ready", 32'(r_in_ready), 32'(exp_q.size() < 2));
      if (r_out_valid && r_out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_out", 32'(r_out_data), 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          check("rand_data", 32'(r_out_data), 32'(exp_word));
          $display("t=%0t rand deliver %h", $time, r_out_data);
        end
      end
      if (r_in_valid && r_in_ready) begin
        exp_q.push_back(r_in_data);
      end
      @(posedge clk);
      #1;
    end
    // Drain remaining payloads
    r_in_valid  = 1'b0;
    r_out_ready = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (r_out_valid) begin
        if (exp_q.size() == 0) begin
          check("drain_unexpected_out", 32'(r_out_data), 32'hFFFF_FFFF);
        end else begin
          exp_word = exp_q.pop_front();
          check("drain_data", 32'(r_out_data), 32'(exp_word));
          $display("t=%0t drain deliver %h", $time, r_out_data);
        end
      end
      @(posedge clk);
      #1;
    end
    check("drain_empty", 32'(r_out_valid), 32'd0);
    check("drain_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
